// File: rtl/wb_clint_arbiter.sv
// wb_clint_arbiter
//   Shares one Wishbone B4 CLINT slave port between NUM_MASTERS requesters.
//   Grants are registered round-robin and held for the whole cyc window (bus
//   lock). A watchdog answers the granted master with err when the slave
//   leaves a strobe unacknowledged for TIMEOUT cycles (TIMEOUT=0 disables it).
//
//   Ports:
//     clk_i    system clock
//     rst_i    synchronous, active-high reset
//     wb_m_i   requests from masters (cyc, stb, we, adr, dat)
//     wb_s_o   responses to masters (dat, ack, err, rty, stall)
//     wb_m_o   request forwarded to the CLINT slave
//     wb_s_i   response from the CLINT slave
//     grant_o  one-hot current grant, all-zero when idle

package wb_clint_pkg;
  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } wb_master_t;

  typedef struct packed {
    logic [31:0] dat;
    logic        ack;
    logic        err;
    logic        rty;
    logic        stall;
  } wb_slave_t;
endpackage

module wb_clint_arbiter
  import wb_clint_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned TIMEOUT     = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  wb_master_t             wb_m_i [NUM_MASTERS],
  output wb_slave_t              wb_s_o [NUM_MASTERS],
  output wb_master_t             wb_m_o,
  input  wb_slave_t              wb_s_i,
  output logic [NUM_MASTERS-1:0] grant_o
);

  localparam int unsigned   IW      = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int unsigned   CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMO_MAX = CW'(TIMEOUT);

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  state_e                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IW-1:0]          rr_q, rr_d;
  logic [CW-1:0]          tmo_cnt_q, tmo_cnt_d;

  logic [IW-1:0] gidx;
  logic [IW-1:0] cand;
  logic [IW-1:0] pick;
  logic          found;
  logic          g_cyc;
  logic          g_stb;
  logic          tmo_hit;

  // Index of the granted master, decoded from the one-hot grant register.
  always_comb begin
    gidx = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (grant_q[i]) gidx = IW'(i);
    end
  end

  assign g_cyc   = wb_m_i[gidx].cyc;
  assign g_stb   = wb_m_i[gidx].stb;
  assign tmo_hit = (TIMEOUT != 0) && (state_q == BUSY) && (tmo_cnt_q == TMO_MAX);
  assign grant_o = grant_q;

  // Round-robin search starting at rr_q; first requester found wins.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int unsigned off = 0; off < NUM_MASTERS; off++) begin
      cand = IW'((32'(rr_q) + off) % NUM_MASTERS);
      if (!found && wb_m_i[cand].cyc) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    tmo_cnt_d = '0;

    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = BUSY;
          grant_d = NUM_MASTERS'(1) << pick;
          rr_d    = (pick == IW'(NUM_MASTERS - 1)) ? '0 : pick + IW'(1);
        end
      end
      BUSY: begin
        if (!g_cyc) begin
          state_d = IDLE;
          grant_d = '0;
        end
        // Count only unanswered strobes; the cycle that fires err restarts it.
        if ((TIMEOUT != 0) && g_cyc && g_stb && !wb_s_i.ack && !wb_s_i.err && !tmo_hit) begin
          tmo_cnt_d = tmo_cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      rr_q      <= '0;
      tmo_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_q      <= rr_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  // Bus routing: the granted master is passed straight through in BUSY;
  // everyone else is stalled with a quiet response.
  always_comb begin
    wb_m_o = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      wb_s_o[i]       = '0;
      wb_s_o[i].stall = 1'b1;
    end
    if (state_q == BUSY) begin
      wb_m_o       = wb_m_i[gidx];
      wb_s_o[gidx] = wb_s_i;
      if (tmo_hit) begin
        wb_m_o.stb       = 1'b0;
        wb_s_o[gidx].ack = 1'b0;
        wb_s_o[gidx].err = 1'b1;
      end
    end
  end

  grant_onehot0_a: assert property (@(posedge clk_i) $onehot0(grant_q));

endmodule

// File: tb/tb_wb_clint_arbiter.sv
module tb_wb_clint_arbiter;
  import wb_clint_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Two-master instance with the default watchdog
  wb_master_t m_drv [2];
  wb_slave_t  s_out [2];
  wb_master_t fwd;
  wb_slave_t  s_in;
  logic [1:0] grant;
  logic       ack_en = 1'b1;

  // Three-master instance for the rotation test
  wb_master_t m3_drv [3];
  wb_slave_t  s3_out [3];
  wb_master_t fwd3;
  wb_slave_t  s3_in;
  logic [2:0] grant3;

  wb_clint_arbiter #(.NUM_MASTERS(2), .TIMEOUT(16)) dut (
    .clk_i(clk), .rst_i(rst), .wb_m_i(m_drv), .wb_s_o(s_out),
    .wb_m_o(fwd), .wb_s_i(s_in), .grant_o(grant)
  );

  wb_clint_arbiter #(.NUM_MASTERS(3), .TIMEOUT(4)) dut3 (
    .clk_i(clk), .rst_i(rst), .wb_m_i(m3_drv), .wb_s_o(s3_out),
    .wb_m_o(fwd3), .wb_s_i(s3_in), .grant_o(grant3)
  );

  function automatic logic [31:0] rdata(input logic [31:0] a);
    return a ^ 32'hC11E_0000;
  endfunction

  // Zero-wait slave models
  assign s_in.ack   = ack_en & fwd.cyc & fwd.stb;
  assign s_in.dat   = s_in.ack ? rdata(fwd.adr) : 32'h0;
  assign s_in.err   = 1'b0;
  assign s_in.rty   = 1'b0;
  assign s_in.stall = 1'b0;

  assign s3_in.ack   = fwd3.cyc & fwd3.stb;
  assign s3_in.dat   = 32'h0;
  assign s3_in.err   = 1'b0;
  assign s3_in.rty   = 1'b0;
  assign s3_in.stall = 1'b0;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Response scoreboard for the two-master instance
  typedef struct {
    int          mst;
    logic        is_err;
    logic [31:0] dat;
  } resp_t;
  resp_t sb[$];

  task automatic sb_push(input int mst, input logic is_err, input logic [31:0] dat);
    resp_t r;
    r.mst = mst; r.is_err = is_err; r.dat = dat;
    sb.push_back(r);
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (s_out[i].ack || s_out[i].err) begin
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL sb_unexpected: master %0d got ack=%0b err=%0b, required none", i, s_out[i].ack, s_out[i].err);
        end else begin
          resp_t e;
          e = sb.pop_front();
          chk("sb_master", 96'(i), 96'(e.mst));
          chk("sb_kind", {s_out[i].ack, s_out[i].err}, {~e.is_err, e.is_err});
          if (!e.is_err) chk("sb_rdata", s_out[i].dat, e.dat);
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic set_m(input int i, input logic c, input logic s);
    m_drv[i].cyc = c;
    m_drv[i].stb = s;
  endtask

  typedef struct {
    logic       rst;
    logic [1:0] cyc;    // bit i: master i asserts cyc and stb
    logic [1:0] grant;
    logic       fwd;    // slave sees the granted request
    logic [1:0] ack;
    logic [1:0] stall;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic [1:0] c, input logic [1:0] g,
                              input logic f, input logic [1:0] a, input logic [1:0] s);
    vec_t v;
    v.rst = r; v.cyc = c; v.grant = g; v.fwd = f; v.ack = a; v.stall = s;
    return v;
  endfunction

  vec_t vecs[18];

  initial begin
    logic [2:0] got_ack;
    logic [2:0] prev_g;
    int unsigned nseen;
    int unsigned idle_run;

    // Single transactions, rr from both phases, then reset and simultaneous start
    vecs[0]  = mk(0, 2'b01, 2'b00, 0, 2'b00, 2'b11);
    vecs[1]  = mk(0, 2'b01, 2'b01, 1, 2'b01, 2'b10);
    vecs[2]  = mk(0, 2'b00, 2'b01, 0, 2'b00, 2'b10);
    vecs[3]  = mk(0, 2'b00, 2'b00, 0, 2'b00, 2'b11);
    vecs[4]  = mk(0, 2'b11, 2'b00, 0, 2'b00, 2'b11);
    vecs[5]  = mk(0, 2'b11, 2'b10, 1, 2'b10, 2'b01);
    vecs[6]  = mk(0, 2'b01, 2'b10, 0, 2'b00, 2'b01);
    vecs[7]  = mk(0, 2'b01, 2'b00, 0, 2'b00, 2'b11);
    vecs[8]  = mk(0, 2'b01, 2'b01, 1, 2'b01, 2'b10);
    vecs[9]  = mk(0, 2'b00, 2'b01, 0, 2'b00, 2'b10);
    vecs[10] = mk(1, 2'b00, 2'b00, 0, 2'b00, 2'b11);
    vecs[11] = mk(0, 2'b11, 2'b00, 0, 2'b00, 2'b11);
    vecs[12] = mk(0, 2'b11, 2'b01, 1, 2'b01, 2'b10);
    vecs[13] = mk(0, 2'b10, 2'b01, 0, 2'b00, 2'b10);
    vecs[14] = mk(0, 2'b10, 2'b00, 0, 2'b00, 2'b11);
    vecs[15] = mk(0, 2'b10, 2'b10, 1, 2'b10, 2'b01);
    vecs[16] = mk(0, 2'b00, 2'b10, 0, 2'b00, 2'b01);
    vecs[17] = mk(0, 2'b00, 2'b00, 0, 2'b00, 2'b11);

    foreach (m_drv[i])  m_drv[i]  = '0;
    foreach (m3_drv[i]) m3_drv[i] = '0;
    m_drv[0].we  = 1'b1;
    m_drv[0].adr = 32'h0000_4000;
    m_drv[0].dat = 32'h0000_0010;
    m_drv[1].adr = 32'h0000_BFF8;
    m_drv[0].cyc = 1'b1;
    m_drv[0].stb = 1'b1;

    // Reset state while a request is pending
    repeat (2) @(posedge clk);
    sample();
    chk("rst_grant", grant, 2'b00);
    chk("rst_fwd", fwd, '0);
    chk("rst_s0", s_out[0], 36'h1);
    chk("rst_s1", s_out[1], 36'h1);

    foreach (vecs[r]) begin
      vec_t v;
      int   k;
      v = vecs[r];
      next_cycle();
      rst = v.rst;
      for (int i = 0; i < 2; i++) set_m(i, v.cyc[i], v.cyc[i]);
      for (int i = 0; i < 2; i++) if (v.ack[i]) sb_push(i, 1'b0, rdata(m_drv[i].adr));
      sample();
      k = v.grant[1] ? 1 : 0;
      chk($sformatf("vec%0d_grant", r), grant, v.grant);
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("vec%0d_ack%0d", r, i), s_out[i].ack, v.ack[i]);
        chk($sformatf("vec%0d_stall%0d", r, i), s_out[i].stall, v.stall[i]);
        if (!v.grant[i]) chk($sformatf("vec%0d_quiet%0d", r, i), s_out[i], 36'h1);
      end
      if (v.fwd) chk($sformatf("vec%0d_fwd", r), fwd, m_drv[k]);
      else if (v.grant == 2'b00) chk($sformatf("vec%0d_idle_fwd", r), fwd, '0);
      else chk($sformatf("vec%0d_rel_fwd", r), {fwd.cyc, fwd.stb}, 2'b00);
    end

    // Bus lock: M1 does four back-to-back reads while M0 waits (rr_q=0 here)
    next_cycle();
    set_m(1, 1, 1);
    repeat (4) sb_push(1, 1'b0, rdata(32'h0000_BFF8));
    sample();
    chk("t3_idle", grant, 2'b00);
    for (int b = 0; b < 4; b++) begin
      next_cycle();
      if (b == 0) set_m(0, 1, 1);
      sample();
      chk("t3_grant", grant, 2'b10);
      chk("t3_m1_ack", s_out[1].ack, 1'b1);
      chk("t3_fwd_adr", fwd.adr, 32'h0000_BFF8);
      chk("t3_m0_stall", s_out[0].stall, 1'b1);
    end
    next_cycle();
    set_m(1, 0, 0);
    sample();
    chk("t3_drop_grant", grant, 2'b10);
    chk("t3_drop_cyc", fwd.cyc, 1'b0);
    chk("t3_drop_m0_stall", s_out[0].stall, 1'b1);
    next_cycle();
    sample();
    chk("t3_gap", grant, 2'b00);
    next_cycle();
    sb_push(0, 1'b0, rdata(32'h0000_4000));
    sample();
    chk("t3_m0_grant", grant, 2'b01);
    next_cycle();
    set_m(0, 0, 0);
    sample();
    next_cycle();
    sample();
    chk("t3_end", grant, 2'b00);

    // Watchdog: slave never acks, err on the 17th strobe cycle
    next_cycle();
    ack_en = 1'b0;
    set_m(0, 1, 1);
    sb_push(0, 1'b1, 32'h0);
    sample();
    chk("t4_idle", grant, 2'b00);
    for (int n = 1; n <= 17; n++) begin
      next_cycle();
      if (n == 1) set_m(1, 1, 1);
      sample();
      chk($sformatf("t4_grant_%0d", n), grant, 2'b01);
      chk($sformatf("t4_err_%0d", n), s_out[0].err, n == 17);
      chk($sformatf("t4_ack_%0d", n), s_out[0].ack, 1'b0);
      chk($sformatf("t4_stb_%0d", n), fwd.stb, n != 17);
      chk($sformatf("t4_m1_stall_%0d", n), s_out[1].stall, 1'b1);
    end
    next_cycle();
    set_m(0, 0, 0);
    ack_en = 1'b1;
    sample();
    chk("t4_hold_grant", grant, 2'b01);
    chk("t4_hold_m1_stall", s_out[1].stall, 1'b1);
    next_cycle();
    sample();
    chk("t4_gap", grant, 2'b00);
    next_cycle();
    sb_push(1, 1'b0, rdata(32'h0000_BFF8));
    sample();
    chk("t4_m1_grant", grant, 2'b10);
    next_cycle();
    set_m(1, 0, 0);
    sample();
    next_cycle();
    sample();
    chk("t4_end", grant, 2'b00);

    // Reset in the middle of a transaction (M0 granted first so rr_q=1)
    next_cycle();
    ack_en = 1'b0;
    set_m(0, 1, 1);
    sample();
    next_cycle();
    sample();
    chk("t5_busy", grant, 2'b01);
    next_cycle();
    rst = 1'b1;
    set_m(1, 1, 1);
    sample();
    next_cycle();
    rst = 1'b0;
    ack_en = 1'b1;
    sample();
    chk("t5_grant", grant, 2'b00);
    chk("t5_cyc", fwd.cyc, 1'b0);
    chk("t5_no_resp", {s_out[0].ack, s_out[0].err}, 2'b00);
    next_cycle();
    sb_push(0, 1'b0, rdata(32'h0000_4000));
    sample();
    chk("t5_rr_reset", grant, 2'b01);
    next_cycle();
    set_m(0, 0, 0);
    sample();
    next_cycle();
    sample();
    next_cycle();
    sb_push(1, 1'b0, rdata(32'h0000_BFF8));
    sample();
    chk("t5_m1_grant", grant, 2'b10);
    next_cycle();
    set_m(1, 0, 0);
    sample();
    next_cycle();
    sample();

    // Three masters requesting continuously with one-beat transactions
    got_ack  = '0;
    prev_g   = '0;
    nseen    = 0;
    idle_run = 0;
    for (int c = 0; c < 60 && nseen < 6; c++) begin
      next_cycle();
      for (int i = 0; i < 3; i++) begin
        m3_drv[i].cyc = ~got_ack[i];
        m3_drv[i].stb = ~got_ack[i];
      end
      sample();
      for (int i = 0; i < 3; i++) got_ack[i] = s3_out[i].ack;
      if (grant3 == 3'b000) begin
        idle_run++;
      end else if (grant3 != prev_g) begin
        logic [2:0] exp_g;
        exp_g = 3'b001 << (nseen % 3);
        chk($sformatf("t6_order_%0d", nseen), grant3, exp_g);
        chk($sformatf("t6_ack_%0d", nseen), s3_out[nseen % 3].ack, 1'b1);
        if (nseen > 0) chk($sformatf("t6_gap_%0d", nseen), idle_run, 1);
        nseen++;
        idle_run = 0;
      end
      prev_g = grant3;
    end
    chk("t6_count", nseen, 6);
    next_cycle();
    foreach (m3_drv[i]) m3_drv[i] = '0;
    repeat (3) next_cycle();

    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
